// File: rtl/clkgen_100hz_axil_slave.sv
// clkgen_100hz_axil_slave: AXI4-Lite register block (CTRL, HALF_PERIOD, 2 scratch)
// driving a programmable square-wave divider with a rising-edge tick.
module clkgen_100hz_axil_slave #(
  parameter int          C_S00_AXI_DATA_WIDTH = 32,
  parameter int          C_S00_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] RESET_HALF_PERIOD    = 32'd499999
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  output logic                                clk_out,
  output logic                                tick
);
  // State encodings double as the registered handshake outputs.
  typedef enum logic [1:0] {W_IDLE = 2'b00, W_ACCEPT = 2'b01, W_RESP = 2'b10} wr_state_t;
  typedef enum logic [1:0] {R_RESET = 2'b00, R_IDLE = 2'b01, R_DATA = 2'b10} rd_state_t;
  wr_state_t   wr_q;
  rd_state_t   rd_q;
  logic [31:0] regs_q [4];
  logic [31:0] rdata_q, cnt_q, cnt_d;
  logic        clk_q, clk_d, tick_q, tick_d, wrap;
  logic        unused_ok;
  assign unused_ok       = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
  assign s00_axi_awready = wr_q[0];
  assign s00_axi_wready  = wr_q[0];
  assign s00_axi_bvalid  = wr_q[1];
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = rd_q[0];
  assign s00_axi_rvalid  = rd_q[1];
  assign s00_axi_rresp   = 2'b00;
  assign s00_axi_rdata   = rdata_q;
  assign clk_out         = clk_q;
  assign tick            = tick_q;
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_q   <= W_IDLE;
      regs_q <= '{32'd0, RESET_HALF_PERIOD, 32'd0, 32'd0};
    end else begin
      unique case (wr_q)
        W_IDLE:   if (s00_axi_awvalid && s00_axi_wvalid) wr_q <= W_ACCEPT;
        W_ACCEPT: begin
          wr_q <= W_RESP;
          for (int b = 0; b < 4; b++)
            if (s00_axi_wstrb[b]) regs_q[s00_axi_awaddr[3:2]][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
        end
        W_RESP:   if (s00_axi_bready) wr_q <= W_IDLE;
        default:  wr_q <= W_IDLE;
      endcase
    end
  end
  // R_RESET keeps arready low for the first cycle out of reset.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rd_q    <= R_RESET;
      rdata_q <= 32'd0;
    end else begin
      unique case (rd_q)
        R_RESET: rd_q <= R_IDLE;
        R_IDLE:  if (s00_axi_arvalid) begin
          rd_q    <= R_DATA;
          rdata_q <= regs_q[s00_axi_araddr[3:2]];
        end
        R_DATA:  if (s00_axi_rready) rd_q <= R_IDLE;
        default: rd_q <= R_IDLE;
      endcase
    end
  end
  always_comb begin
    wrap   = cnt_q >= regs_q[1];
    cnt_d  = (regs_q[0][0] && !wrap) ? cnt_q + 32'd1 : 32'd0;
    clk_d  = regs_q[0][0] && (clk_q ^ wrap);
    tick_d = regs_q[0][0] && wrap && !clk_q;
  end
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      cnt_q  <= 32'd0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end
endmodule

// File: tb/tb_clkgen_100hz_axil_slave.sv
// tb_clkgen_100hz_axil_slave: directed AXI-Lite traffic with a timestamp-based
// generator model and read-expectation queue, plus literal checks.
module tb_clkgen_100hz_axil_slave;
  logic        clk = 0, rst_n = 0;
  logic [3:0]  awaddr = 0, araddr = 0, wstrb = 0;
  logic [2:0]  prot = 0;
  logic [31:0] wdata = 0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid, clk_out, tick;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  int checks = 0, passes = 0;
  always #5 clk = ~clk;
  clkgen_100hz_axil_slave dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(prot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(prot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .clk_out(clk_out), .tick(tick)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  // Model: toggle once (cycles since last toggle or enable) exceeds HALF_PERIOD.
  logic [31:0] m_regs [4];
  logic        m_clk = 0, m_tick = 0;
  int          cyc = 0, last = 0;
  logic [31:0] rdq [$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_regs <= '{32'd0, 32'd499999, 32'd0, 32'd0};
      m_clk  <= 0;
      m_tick <= 0;
      last   <= cyc;
      rdq.delete();
    end else begin
      cyc <= cyc + 1;
      if (!m_regs[0][0]) begin
        m_clk <= 0; m_tick <= 0; last <= cyc + 1;
      end else if (cyc - last >= int'(m_regs[1])) begin
        m_clk <= !m_clk; m_tick <= !m_clk; last <= cyc + 1;
      end else m_tick <= 0;
      if (arvalid && arready) rdq.push_back(m_regs[araddr[3:2]]);
      if (awvalid && wvalid && awready && wready)
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) m_regs[awaddr[3:2]][8*b +: 8] <= wdata[8*b +: 8];
    end
  end
  always @(negedge clk) if (rst_n) begin
    chk("clk_out_model", clk_out, m_clk);
    chk("tick_model", tick, m_tick);
  end
  task automatic check_read(input string name, input logic [31:0] exp);
    chk(name, rdata, exp);
    chk("rresp", rresp, 2'b00);
    if (rdq.size() > 0) chk({name, "_model"}, rdata, rdq.pop_front());
    else chk({name, "_model_empty"}, 32'd0, 32'd1);
  endtask
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, output int edge_cyc);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
    chk("wr_accept", awready && wready, 1);
    @(negedge clk);
    edge_cyc = cyc; awvalid = 0; wvalid = 0;
    chk("awready_one_cycle", awready, 0);
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, 2'b00);
    @(negedge clk);
    bready = 0;
  endtask
  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp, input string name);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    chk("ar_accept", arready, 1);
    @(negedge clk);
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    chk("rvalid", rvalid, 1);
    check_read(name, exp);
    @(negedge clk);
    rready = 0;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int e0, ew, d, t1, n, hi;
    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 0); chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);   chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);   chk("rst_rdata", rdata, 0);
    chk("rst_clk_out", clk_out, 0); chk("rst_tick", tick, 0);
    rst_n = 1;
    axi_read(4'h4, 32'h0007A11F, "rd_hp_reset");
    axi_read(4'h0, 32'h0, "rd_ctrl_reset");
    // Basic register map
    axi_write(4'h0, 32'h1, 4'hF, d);
    axi_write(4'h4, 32'h2, 4'hF, d);
    axi_write(4'h8, 32'h3, 4'hF, d);
    axi_write(4'hC, 32'h4, 4'hF, d);
    axi_read(4'h0, 32'h1, "rd_ctrl");
    axi_read(4'h4, 32'h2, "rd_hp");
    axi_read(4'h8, 32'h3, "rd_s0");
    axi_read(4'hC, 32'h4, "rd_s1");
    // Byte strobes, zero strobe, ignored low address bits
    axi_write(4'h8, 32'hAABBCCDD, 4'hF, d);
    axi_write(4'h8, 32'h11223344, 4'b0101, d);
    axi_read(4'h8, 32'hAA22CC44, "rd_strobe");
    axi_write(4'hC, 32'hFFFFFFFF, 4'h0, d);
    axi_read(4'hC, 32'h4, "rd_zero_strobe");
    axi_read(4'hB, 32'hAA22CC44, "rd_low_bits");
    // HALF_PERIOD=4: latency 5, period 10, 5 cycles high
    axi_write(4'h0, 32'h0, 4'hF, d);
    axi_write(4'h4, 32'h4, 4'hF, d);
    axi_write(4'h0, 32'h1, 4'hF, e0);
    n = 0;
    while (!tick && n < 50) begin @(negedge clk); n++; end
    t1 = cyc;
    chk("enable_latency", t1 - e0, 5);
    chk("tick_with_rise", clk_out, 1);
    hi = 1; n = 0;
    do begin @(negedge clk); n++; if (!tick) hi += clk_out; end while (!tick && n < 50);
    chk("period", cyc - t1, 10);
    chk("high_cycles", hi, 5);
    // Lower HALF_PERIOD below the running count
    axi_write(4'h0, 32'h0, 4'hF, d);
    axi_write(4'h4, 32'h9, 4'hF, d);
    axi_write(4'h0, 32'h1, 4'hF, e0);
    while (cyc < e0 + 5) @(negedge clk);
    axi_write(4'h4, 32'h2, 4'hF, ew);
    chk("hp_write_edge", ew - e0, 8);
    chk("hp_drop_rise", clk_out, 1);
    chk("hp_drop_tick", tick, 1);
    repeat (3) @(negedge clk);
    chk("hp2_fall", clk_out, 0);
    repeat (3) @(negedge clk);
    chk("hp2_rise", clk_out, 1);
    chk("hp2_tick", tick, 1);
    axi_write(4'h0, 32'h0, 4'hF, d);
    chk("disable_low", clk_out, 0);
    // B stall with a second AW/W pending, then R stall
    @(negedge clk);
    awaddr = 4'h8; wdata = 32'h5A5A0001; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    awaddr = 4'hC; wdata = 32'hC0DE0002;
    repeat (5) begin
      chk("bvalid_held", bvalid, 1);
      chk("no_awready_while_b", awready, 0);
      @(negedge clk);
    end
    bready = 1;
    @(negedge clk);
    chk("b_done", bvalid, 0);
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    chk("second_accept", awready, 1);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk("second_bvalid", bvalid, 1);
    @(negedge clk);
    bready = 0;
    araddr = 4'hC; arvalid = 1; rready = 0;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 0;
    check_read("rd_stall", 32'hC0DE0002);
    repeat (4) begin
      @(negedge clk);
      chk("rvalid_held", rvalid, 1);
      chk("rdata_stable", rdata, 32'hC0DE0002);
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    chk("r_done", rvalid, 0);
    axi_read(4'h8, 32'h5A5A0001, "rd_first_stalled_wr");
    // Read and write of the same register on the same edge
    @(negedge clk);
    awaddr = 4'h8; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    @(negedge clk);
    araddr = 4'h8; arvalid = 1; rready = 1;
    chk("same_edge_awready", awready, 1);
    chk("same_edge_arready", arready, 1);
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("same_edge_bvalid", bvalid, 1);
    check_read("rd_pre_write", 32'h5A5A0001);
    @(negedge clk);
    bready = 0; rready = 0;
    axi_read(4'h8, 32'h0BADF00D, "rd_post_write");
    // Reset in the middle of a write aborts it
    @(negedge clk);
    awaddr = 4'h8; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    #2 rst_n = 0;
    #1;
    chk("mid_rst_awready", awready, 0);
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_arready", arready, 0);
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("mid_rst_bvalid_later", bvalid, 0);
    rst_n = 1;
    axi_read(4'h8, 32'h0, "rd_s0_after_reset");
    axi_read(4'h4, 32'h0007A11F, "rd_hp_after_reset");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
